// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit: RV32I funct3 encodings for the
//   memory instructions and the state type of the read-modify-write FSM.
//   No ports (package).
// -----------------------------------------------------------------------------
package lsu_pkg;

    // funct3 size/sign encodings (shared by loads and stores)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, WRITE} lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
//   Combinational load-data alignment: selects the addressed byte or halfword
//   lane from the memory word and sign- or zero-extends it according to funct3.
//   Little-endian lane order (byte 0 = bits [7:0]).
// Ports
//   mem_rdata  in   32  word read from data memory
//   addr_lo    in   2   low byte-address bits (byte lane; [1] is the half lane)
//   funct3     in   3   load size/sign encoding
//   rd_data    out  32  extended load result; 0 for unsupported encodings
// -----------------------------------------------------------------------------
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] rd_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase

        // addr_lo[0] is ignored for halfwords: misaligned halfwords either
        // trap upstream or fall back to the containing aligned lane.
        half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        rd_data = '0;
        case (funct3)
            F3_B:    rd_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    rd_data = {{16{half_sel[15]}}, half_sel};
            F3_W:    rd_data = mem_rdata;
            F3_BU:   rd_data = {24'd0, byte_sel};
            F3_HU:   rd_data = {16'd0, half_sel};
            default: rd_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Bridges the single-cycle core's execute stage to a data memory that only
//   has a word-wide write port and a combinational read. Loads of any size
//   complete in the same cycle. Word stores write in the same cycle. Byte and
//   halfword stores take two cycles: the first reads the word and merges the
//   new lane into merge_q while stalling the core, the second writes it back.
//
// Optional build macro
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses raise
//                         misalign and are suppressed; when undefined the
//                         offending low address bits are ignored.
//
// Ports
//   clk        in   1           clock, all state on posedge
//   rst_n      in   1           asynchronous active-low reset
//   req_valid  in   1           memory instruction present (held while stall=1)
//   req_we     in   1           1 = store, 0 = load
//   req_funct3 in   3           RV32I funct3
//   req_addr   in   ADDR_WIDTH  byte address
//   req_wdata  in   DATA_WIDTH  store data (low bits)
//   rd_data    out  DATA_WIDTH  extended load result (combinational)
//   stall      out  1           hold the core this cycle
//   misalign   out  1           misaligned access flag
//   mem_we     out  1           data memory write enable
//   mem_addr   out  ADDR_WIDTH  data memory word address ([1:0] = 0)
//   mem_wdata  out  DATA_WIDTH  data memory write data
//   mem_rdata  in   DATA_WIDTH  data memory combinational read data
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  stall,
    output logic                  misalign,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_t            state_q;
    logic [DATA_WIDTH-1:0] merge_q;
    logic [ADDR_WIDTH-1:0] waddr_q;

    logic                  in_idle;
    logic                  f3_load_ok;
    logic                  f3_store_ok;
    logic                  f3_ok;
    logic                  misalign_raw;
    logic                  dec_load;
    logic                  dec_sw;
    logic                  dec_rmw;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [DATA_WIDTH-1:0] merge_next;
    logic [DATA_WIDTH-1:0] align_data;

    assign in_idle   = (state_q == IDLE);
    assign word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};

    assign f3_load_ok  = (req_funct3 == F3_B)  || (req_funct3 == F3_H) ||
                         (req_funct3 == F3_W)  || (req_funct3 == F3_BU) ||
                         (req_funct3 == F3_HU);
    assign f3_store_ok = (req_funct3 == F3_B)  || (req_funct3 == F3_H) ||
                         (req_funct3 == F3_W);
    assign f3_ok       = req_we ? f3_store_ok : f3_load_ok;

`ifdef LSU_MISALIGN_TRAP_EN
    // funct3[1:0] carries the access size for both loads and stores.
    assign misalign_raw = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign_raw = 1'b0;
`endif

    // Request decode, deliberately independent of rst_n so that the reset
    // net only feeds the asynchronous flop reset and the output gating.
    assign dec_load = in_idle && req_valid && !req_we && f3_load_ok && !misalign_raw;
    assign dec_sw   = in_idle && req_valid && req_we && f3_store_ok && !misalign_raw &&
                      (req_funct3 == F3_W);
    assign dec_rmw  = in_idle && req_valid && req_we && f3_store_ok && !misalign_raw &&
                      (req_funct3 != F3_W);

    lsu_load_align u_load_align (
        .mem_rdata (mem_rdata),
        .addr_lo   (req_addr[1:0]),
        .funct3    (req_funct3),
        .rd_data   (align_data)
    );

    // Replace the addressed lane of the freshly read word with store data.
    always_comb begin
        merge_next = mem_rdata;
        if (req_funct3 == F3_B) begin
            case (req_addr[1:0])
                2'd0:    merge_next[7:0]   = req_wdata[7:0];
                2'd1:    merge_next[15:8]  = req_wdata[7:0];
                2'd2:    merge_next[23:16] = req_wdata[7:0];
                default: merge_next[31:24] = req_wdata[7:0];
            endcase
        end else if (req_addr[1]) begin
            merge_next[31:16] = req_wdata[15:0];
        end else begin
            merge_next[15:0]  = req_wdata[15:0];
        end
    end

    // Outputs are forced quiet while reset is held.
    assign rd_data   = (rst_n && dec_load) ? align_data : '0;
    assign stall     = rst_n && dec_rmw;
    assign misalign  = rst_n && in_idle && req_valid && f3_ok && misalign_raw;
    assign mem_we    = rst_n && (!in_idle || dec_sw);
    assign mem_addr  = in_idle ? word_addr : waddr_q;
    assign mem_wdata = in_idle ? req_wdata : merge_q;

    // WRITE always returns to IDLE, so the write-back finishes even if the
    // core drops req_valid; a reset during WRITE simply discards merge_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            merge_q <= '0;
            waddr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dec_rmw) begin
                        merge_q <= merge_next;
                        waddr_q <= word_addr;
                        state_q <= WRITE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
